// File: rtl/riscv_multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences a shared-ALU, shared-memory
// datapath for lw, sw, R-type, I-type ALU, beq and jal. Moore outputs are
// decoded from the state register, except for three paths. IRWrite and
// PCUpdate follow mem_ready in FETCH. MemWrite is held until mem_ready,
// with retire following mem_ready in MEMWRITE. PCWrite follows Zero in BEQ.
//
// Memory handshake: the controller raises a request (FETCH read via
// AdrSrc=0, MEMREAD read or MEMWRITE write via AdrSrc=1) and holds every
// output stable until the memory reports mem_ready=1 in the same cycle.
// The access completes in that cycle, and the FSM advances on the next
// rising edge.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       retire_raw;
  logic       illegal_raw;

  // State register: the only flop in the block, cleared to FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state control decode; anything not set stays 0.
  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    AdrSrc        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    illegal_raw   = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_raw = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder: fixed add/sub, or funct decode; sub needs op[5] so addi never subtracts.
  always_comb begin
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is held.
  assign PCWrite  = rst_n & (pc_update | (branch & Zero));
  assign IRWrite  = rst_n & ir_write_raw;
  assign MemWrite = rst_n & mem_write_raw;
  assign RegWrite = rst_n & reg_write_raw;
  assign retire   = rst_n & retire_raw;
  assign illegal  = rst_n & illegal_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Cycle-accurate bench for riscv_multicycle_controller. Each scenario queues
// per-cycle stimulus and the expected output vector; the run loop inside the
// scenario pops both, drives the inputs after the falling edge and compares
// one time unit later.
module tb_riscv_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  // Clock / reset block
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = OP_SW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  riscv_multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .retire(retire),
    .illegal(illegal), .state(state)
  );

  // Scoreboard: {rst_n, mem_ready, Zero, op, funct3, funct7} and expected outputs
  logic [13:0] stim_q[$];
  logic [21:0] exp_q[$];
  logic [13:0] s;
  logic [21:0] e, o;
  int total = 0;
  int bad = 0;

  // Expected vector layout:
  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
  //  ALUControl, ImmSrc, RegWrite, retire, illegal}
  function automatic logic [21:0] v(input logic [3:0] st, input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                    input logic [1:0] imm, input logic rw, ret, ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret, ill};
  endfunction

  function automatic logic [21:0] obs();
    return {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, RegWrite, retire, illegal};
  endfunction

  // Driver tasks: queue one cycle of stimulus with its expected outputs
  task automatic plan(input logic rst, rdy, z, input logic [6:0] o7, input logic [2:0] f3,
                      input logic f7, input logic [21:0] ev);
    stim_q.push_back({rst, rdy, z, o7, f3, f7});
    exp_q.push_back(ev);
  endtask

  task automatic plan_fetch(input logic [6:0] o7, input logic [2:0] f3, input logic f7,
                            input logic [1:0] imm, input int nstall);
    for (int i = 0; i < nstall; i++)
      plan(1'b1, 1'b0, 1'($urandom_range(0, 1)), o7, f3, f7,
           v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, 0));
    plan(1'b1, 1'b1, 1'($urandom_range(0, 1)), o7, f3, f7,
         v(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, 0));
  endtask

  task automatic plan_decode(input logic [6:0] o7, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm);
    plan(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o7, f3, f7,
         v(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0, 0));
  endtask

  task automatic test_reset();
    string name = "reset";
    logic [21:0] rv = v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0, 0);
    plan(1'b0, 1'b1, 1'b1, OP_SW, 3'b010, 1'b0, rv);
    plan(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, rv);
    plan_fetch(OP_SW, 3'b010, 1'b0, 2'b01, 1);
    plan_decode(OP_SW, 3'b010, 1'b0, 2'b01);
    plan(1'b1, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0,
         v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0, 0));
    plan(1'b1, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0,
         v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0));
    // reset lands mid-MEMWRITE with mem_ready high: the write must not complete
    plan(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, rv);
    plan(1'b1, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0,
         v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  task automatic test_lw();
    string name = "lw";
    for (int k = 0; k < 2; k++) begin
      int fs = (k == 0) ? 0 : 1;
      int ms = (k == 0) ? 0 : 2;
      plan_fetch(OP_LW, 3'b010, 1'b0, 2'b00, fs);
      plan_decode(OP_LW, 3'b010, 1'b0, 2'b00);
      plan(1'b1, 1'b1, 1'($urandom_range(0, 1)), OP_LW, 3'b010, 1'b0,
           v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0));
      for (int i = 0; i < ms; i++)
        plan(1'b1, 1'b0, 1'($urandom_range(0, 1)), OP_LW, 3'b010, 1'b0,
             v(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0));
      plan(1'b1, 1'b1, 1'($urandom_range(0, 1)), OP_LW, 3'b010, 1'b0,
           v(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0));
      plan(1'b1, 1'b1, 1'($urandom_range(0, 1)), OP_LW, 3'b010, 1'b0,
           v(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0));
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  task automatic test_sw();
    string name = "sw";
    plan_fetch(OP_SW, 3'b010, 1'b0, 2'b01, 0);
    plan_decode(OP_SW, 3'b010, 1'b0, 2'b01);
    plan(1'b1, 1'b1, 1'b1, OP_SW, 3'b010, 1'b0,
         v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      plan(1'b1, 1'b0, 1'($urandom_range(0, 1)), OP_SW, 3'b010, 1'b0,
           v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0));
    plan(1'b1, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0,
         v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  // Back-to-back R/I instructions covering each funct3 decode
  task automatic test_alu();
    string name = "alu";
    logic [6:0]  t_op[9]  = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I};
    logic [2:0]  t_f3[9]  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001,
                              3'b000, 3'b010, 3'b111};
    logic        t_f7[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  t_alu[9] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000,
                              3'b000, 3'b101, 3'b010};
    for (int k = 0; k < 9; k++) begin
      logic is_r = (t_op[k] == OP_R);
      plan_fetch(t_op[k], t_f3[k], t_f7[k], 2'b00, $urandom_range(0, 1));
      plan_decode(t_op[k], t_f3[k], t_f7[k], 2'b00);
      plan(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t_op[k], t_f3[k], t_f7[k],
           v(is_r ? 4'd6 : 4'd7, 0, 0, 0, 0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01,
             t_alu[k], 2'b00, 0, 0, 0));
      plan(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t_op[k], t_f3[k], t_f7[k],
           v(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0));
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  task automatic test_beq();
    string name = "beq";
    for (int k = 0; k < 2; k++) begin
      logic z = (k == 0);
      plan_fetch(OP_BEQ, 3'b000, 1'b0, 2'b10, 0);
      plan_decode(OP_BEQ, 3'b000, 1'b0, 2'b10);
      plan(1'b1, 1'($urandom_range(0, 1)), z, OP_BEQ, 3'b000, 1'b0,
           v(4'd10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1, 0));
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  task automatic test_jal();
    string name = "jal";
    plan_fetch(OP_JAL, 3'b000, 1'b0, 2'b11, 2);
    plan_decode(OP_JAL, 3'b000, 1'b0, 2'b11);
    plan(1'b1, 1'($urandom_range(0, 1)), 1'b0, OP_JAL, 3'b000, 1'b0,
         v(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0, 0));
    plan(1'b1, 1'($urandom_range(0, 1)), 1'b1, OP_JAL, 3'b000, 1'b0,
         v(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  task automatic test_illegal();
    string name = "illegal";
    plan_fetch(OP_BAD, 3'b000, 1'b0, 2'b00, 0);
    plan_decode(OP_BAD, 3'b000, 1'b0, 2'b00);
    for (int i = 0; i < 24; i++)
      plan(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), OP_BAD, 3'b000, 1'b0,
           v(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 1));
    plan(1'b0, 1'b1, 1'b0, OP_BAD, 3'b000, 1'b0,
         v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0));
    plan(1'b1, 1'b1, 1'b0, OP_BAD, 3'b000, 1'b0,
         v(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {rst_n, mem_ready, Zero, op, funct3, funct7} = s;
      #1;
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: state=%0d got=%h exp=%h", name, state, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
